// File: rtl/zap_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter for NUM_MASTERS requesters sharing one bus.
// A grant is held for a full burst and released on end-of-burst, a classic ack, or an abort.
module zap_wb_rr_arbiter #(
   parameter int NUM_MASTERS = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [NUM_MASTERS-1:0]    i_m_wb_cyc,
   input  logic [NUM_MASTERS-1:0]    i_m_wb_stb,
   input  logic [NUM_MASTERS-1:0]    i_m_wb_wen,
   input  logic [4*NUM_MASTERS-1:0]  i_m_wb_sel,
   input  logic [32*NUM_MASTERS-1:0] i_m_wb_dat,
   input  logic [32*NUM_MASTERS-1:0] i_m_wb_adr,
   input  logic [3*NUM_MASTERS-1:0]  i_m_wb_cti,
   output logic [NUM_MASTERS-1:0]    o_m_wb_ack,
   output logic                      o_wb_cyc,
   output logic                      o_wb_stb,
   output logic                      o_wb_wen,
   output logic [3:0]                o_wb_sel,
   output logic [31:0]               o_wb_dat,
   output logic [31:0]               o_wb_adr,
   output logic [2:0]                o_wb_cti,
   input  logic                      i_wb_ack,
   output logic [NUM_MASTERS-1:0]    o_grant
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t                 state_q;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [IW-1:0]          last_q;

   logic [IW-1:0]          pick_idx_d;
   logic                   pick_found_d;
   logic [NUM_MASTERS-1:0] pick_onehot_d;
   logic [2:0]             cti_mux;
   logic                   release_d;

   // Search order starts one past the last winner and wraps; the sum never exceeds IW+1 bits.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      logic [IW:0] sum;
      pick_idx_d   = last_q;
      pick_found_d = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         sum = {1'b0, last_q} + (IW+1)'(i);
         if (sum >= (IW+1)'(NUM_MASTERS)) sum = sum - (IW+1)'(NUM_MASTERS);
         if (!pick_found_d && i_m_wb_stb[sum[IW-1:0]]) begin
            pick_found_d = 1'b1;
            pick_idx_d   = sum[IW-1:0];
         end
      end
      pick_onehot_d = NUM_MASTERS'(1) << pick_idx_d;
   end

   // AND-OR mux keyed by the one-hot grant; an empty grant yields the idle bus values.
   always_comb begin
      o_wb_cyc = 1'b0;
      o_wb_stb = 1'b0;
      o_wb_wen = 1'b0;
      o_wb_sel = '0;
      o_wb_dat = '0;
      o_wb_adr = '0;
      cti_mux  = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (grant_q[k]) begin
            o_wb_cyc = o_wb_cyc | i_m_wb_cyc[k];
            o_wb_stb = o_wb_stb | i_m_wb_stb[k];
            o_wb_wen = o_wb_wen | i_m_wb_wen[k];
            o_wb_sel = o_wb_sel | i_m_wb_sel[4*k +: 4];
            o_wb_dat = o_wb_dat | i_m_wb_dat[32*k +: 32];
            o_wb_adr = o_wb_adr | i_m_wb_adr[32*k +: 32];
            cti_mux  = cti_mux  | i_m_wb_cti[3*k +: 3];
         end
      end
      o_wb_cti = (grant_q == '0) ? 3'b111 : cti_mux;
   end

   assign o_m_wb_ack = grant_q & {NUM_MASTERS{i_wb_ack}};
   assign o_grant    = grant_q;

   // Only o_wb_cyc from the granted master matters for abort detection.
   assign release_d = (i_wb_ack && (o_wb_cti == 3'b111 || o_wb_cti == 3'b000)) || !o_wb_cyc;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_MASTERS - 1);
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_found_d) begin
                  grant_q <= pick_onehot_d;
                  last_q  <= pick_idx_d;
                  state_q <= S_OWN;
               end
            end
            S_OWN: begin
               if (release_d) begin
                  grant_q <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
